// File: rtl/opt_scheduler.sv
// Round-robin share of one opt generator across NREP replicas; optional stats ports via OPT_SCHEDULER_STATS_EN.
// Latency: grant to rep_valid >= 4 cycles (ISSUE, ARM, WAIT.., DONE); one grant in flight.
// Backpressure: requests are level-held until rep_valid; generator stall bounded by WAIT_MAX then aborted.
package opt_scheduler_pkg;
    typedef enum logic [1:0] {
        THR = 2'd0,
        TWO = 2'd1,
        OR1 = 2'd2
    } opt_command_t;

    typedef struct packed {
        logic [15:0] k;
        logic [15:0] l;
        logic [31:0] r_metropolis;
        logic [31:0] r_exchange;
    } opt_t;
endpackage

module opt_scheduler
    import opt_scheduler_pkg::*;
#(
    parameter int NREP     = 8,
    parameter int WAIT_MAX = 1024,
    parameter int IDXW     = $clog2(NREP)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               seed_load,
    input  logic [63:0]        seed,
    input  logic [NREP-1:0]    rep_req,
    input  logic [NREP-1:0]    rep_two,
    output logic [NREP-1:0]    rep_valid,
    output opt_t               rep_opt,
    output logic               gen_run,
    output opt_command_t       gen_opt_command,
    output opt_command_t       gen_opt_com,
    output logic               gen_init,
    output logic [63:0]        gen_seed,
    input  logic               gen_ready,
    input  opt_t               gen_opt,
    output logic               busy,
    output logic [IDXW-1:0]    cur_rep,
    output logic               timeout_err
`ifdef OPT_SCHEDULER_STATS_EN
    ,
    output logic [31:0]        grant_cnt,
    output logic [15:0]        wait_max
`endif
);

    localparam int WCW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state, state_n;
    logic [IDXW-1:0] rr_ptr, rr_ptr_n;
    logic [IDXW-1:0] cur_rep_n;
    logic            two_q, two_n;
    logic [WCW-1:0]  wait_cnt, wait_cnt_n;
    opt_t            rep_opt_n;
    logic            timeout_n;
    logic [63:0]     seed_n;
    opt_command_t    issue_cmd;

    logic [IDXW-1:0] pick, scan;
    logic            found;

    function automatic logic [IDXW-1:0] inc_idx(input logic [IDXW-1:0] v);
        return (v == IDXW'(NREP - 1)) ? '0 : v + IDXW'(1);
    endfunction

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        pick  = rr_ptr;
        scan  = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < NREP; i++) begin
            if (!found && rep_req[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
            scan = inc_idx(scan);
        end
    end

    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        cur_rep_n  = cur_rep;
        two_n      = two_q;
        wait_cnt_n = wait_cnt;
        rep_opt_n  = rep_opt;
        timeout_n  = timeout_err;
        seed_n     = gen_seed;
        case (state)
            S_IDLE: begin
                if (seed_load) begin
                    seed_n  = seed;
                    state_n = S_SEED;
                end else if (enable && found) begin
                    cur_rep_n = pick;
                    two_n     = rep_two[pick];
                    state_n   = S_ISSUE;
                end
            end
            S_SEED:  state_n = S_IDLE;
            S_ISSUE: state_n = S_ARM;
            S_ARM: begin
                // Ready from the previous run is still up here; skip it.
                wait_cnt_n = '0;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                if (gen_ready) begin
                    rep_opt_n = gen_opt;
                    state_n   = S_DONE;
                end else if (wait_cnt == WCW'(WAIT_MAX - 1)) begin
                    timeout_n = 1'b1;
                    rr_ptr_n  = inc_idx(cur_rep);
                    state_n   = S_IDLE;
                end else begin
                    wait_cnt_n = wait_cnt + WCW'(1);
                end
            end
            S_DONE: begin
                rr_ptr_n = inc_idx(cur_rep);
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign issue_cmd = two_n ? TWO : OR1;

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            rr_ptr          <= '0;
            cur_rep         <= '0;
            two_q           <= 1'b0;
            wait_cnt        <= '0;
            rep_opt         <= '0;
            rep_valid       <= '0;
            timeout_err     <= 1'b0;
            gen_seed        <= '0;
            gen_init        <= 1'b0;
            gen_run         <= 1'b0;
            gen_opt_command <= THR;
            gen_opt_com     <= THR;
            busy            <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            cur_rep     <= cur_rep_n;
            two_q       <= two_n;
            wait_cnt    <= wait_cnt_n;
            rep_opt     <= rep_opt_n;
            timeout_err <= timeout_n;
            gen_seed    <= seed_n;
            gen_init    <= (state_n == S_SEED);
            gen_run     <= (state_n == S_ISSUE);
            busy        <= (state_n != S_IDLE);
            gen_opt_com <= (state_n == S_ISSUE) ? issue_cmd : THR;
            if (state_n == S_ISSUE) begin
                gen_opt_command <= issue_cmd;
            end
            rep_valid <= '0;
            if (state_n == S_DONE) begin
                rep_valid[cur_rep_n] <= 1'b1;
            end
        end
    end

`ifdef OPT_SCHEDULER_STATS_EN
    logic [31:0] wc_ext;
    assign wc_ext = 32'(wait_cnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt <= '0;
            wait_max  <= '0;
        end else begin
            if (state == S_DONE) begin
                grant_cnt <= grant_cnt + 32'd1;
            end
            if (state == S_WAIT && wc_ext > 32'(wait_max)) begin
                wait_max <= (wc_ext > 32'h0000_FFFF) ? 16'hFFFF : wc_ext[15:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_opt_scheduler.sv
// Directed bench for opt_scheduler: vector table of single grants plus hand-written seed, round-robin,
// timeout and reset-abort sequences. Inputs driven and outputs sampled on the falling edge.
module tb_opt_scheduler;
    import opt_scheduler_pkg::*;

    localparam int NREP = 8;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            seed_load;
    logic [63:0]     seed;
    logic [NREP-1:0] rep_req;
    logic [NREP-1:0] rep_two;
    logic [NREP-1:0] rep_valid;
    opt_t            rep_opt;
    logic            gen_run;
    opt_command_t    gen_opt_command;
    opt_command_t    gen_opt_com;
    logic            gen_init;
    logic [63:0]     gen_seed;
    logic            gen_ready;
    opt_t            gen_opt;
    logic            busy;
    logic [2:0]      cur_rep;
    logic            timeout_err;

    int errors = 0;
    int checks = 0;

    opt_scheduler #(.NREP(NREP), .WAIT_MAX(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
        .rep_req(rep_req), .rep_two(rep_two), .rep_valid(rep_valid), .rep_opt(rep_opt),
        .gen_run(gen_run), .gen_opt_command(gen_opt_command), .gen_opt_com(gen_opt_com),
        .gen_init(gen_init), .gen_seed(gen_seed), .gen_ready(gen_ready), .gen_opt(gen_opt),
        .busy(busy), .cur_rep(cur_rep), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  req;
        logic [7:0]  two;
        int          dly;
        logic [15:0] k;
        logic [15:0] l;
        int          rep;
        bit          two_exp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " rep_valid"}, rep_valid, 0);
        chk({tag, " rep_opt"}, rep_opt, 0);
        chk({tag, " gen_run"}, gen_run, 0);
        chk({tag, " gen_init"}, gen_init, 0);
        chk({tag, " gen_seed"}, gen_seed, 0);
        chk({tag, " gen_opt_command"}, gen_opt_command, THR);
        chk({tag, " gen_opt_com"}, gen_opt_com, THR);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " cur_rep"}, cur_rep, 0);
        chk({tag, " timeout_err"}, timeout_err, 0);
    endtask

    // Starts on an IDLE falling edge, ends on the IDLE falling edge after DONE.
    task automatic do_grant(input string tag, input logic [7:0] req, input logic [7:0] two,
                            input int dly, input logic [15:0] k, input logic [15:0] l,
                            input int exp_rep, input bit exp_two, input bit drop);
        opt_t         o;
        opt_command_t c;
        o = '{k: k, l: l, r_metropolis: {16'hA5A5, k}, r_exchange: {l, 16'h5A5A}};
        c = exp_two ? TWO : OR1;
        rep_req = req;
        rep_two = two;
        step();
        chk({tag, " issue gen_run"}, gen_run, 1);
        chk({tag, " issue cur_rep"}, cur_rep, exp_rep);
        chk({tag, " issue gen_opt_com"}, gen_opt_com, c);
        chk({tag, " issue busy"}, busy, 1);
        rep_two = ~two;
        if (drop) rep_req = '0;
        step();
        chk({tag, " arm gen_run"}, gen_run, 0);
        chk({tag, " arm gen_opt_com"}, gen_opt_com, THR);
        chk({tag, " arm gen_opt_command"}, gen_opt_command, c);
        step();
        for (int d = 1; d < dly; d++) begin
            chk({tag, " wait rep_valid"}, rep_valid, 0);
            step();
        end
        gen_ready = 1'b1;
        gen_opt   = o;
        step();
        gen_ready = 1'b0;
        gen_opt   = '1;
        chk({tag, " done rep_valid"}, rep_valid, 8'b1 << exp_rep);
        chk({tag, " done rep_opt"}, rep_opt, o);
        step();
        chk({tag, " idle rep_valid"}, rep_valid, 0);
        chk({tag, " idle busy"}, busy, 0);
    endtask

    initial begin
        tbl[0] = '{8'b0000_0100, 8'b0000_0100, 3, 16'd5,      16'd9,      2, 1'b1};
        tbl[1] = '{8'b0000_0101, 8'b0000_0000, 2, 16'h0011,   16'h0022,   0, 1'b0};
        tbl[2] = '{8'b0000_0101, 8'b0000_0100, 1, 16'h0033,   16'h0044,   2, 1'b1};
        tbl[3] = '{8'b1000_0000, 8'b0000_0000, 1, 16'h0007,   16'h0003,   7, 1'b0};
        tbl[4] = '{8'b1000_0001, 8'b1000_0001, 5, 16'hBEEF,   16'hCAFE,   0, 1'b1};
        tbl[5] = '{8'b1000_0001, 8'b0000_0000, 2, 16'h1234,   16'h4321,   7, 1'b0};

        reset     = 1'b0;
        enable    = 1'b1;
        seed_load = 1'b0;
        seed      = '0;
        rep_req   = '0;
        rep_two   = '0;
        gen_ready = 1'b0;
        gen_opt   = '1;
        step();
        step();
        chk_reset("reset");
        reset = 1'b1;
        step();

        // Seed load
        seed_load = 1'b1;
        seed      = 64'h1234_5678_9abc_def0;
        step();
        seed_load = 1'b0;
        seed      = '0;
        chk("seed gen_init", gen_init, 1);
        chk("seed gen_seed", gen_seed, 64'h1234_5678_9abc_def0);
        chk("seed busy", busy, 1);
        step();
        chk("seed end gen_init", gen_init, 0);
        chk("seed end busy", busy, 0);
        chk("seed end gen_seed", gen_seed, 64'h1234_5678_9abc_def0);

        for (int i = 0; i < 6; i++) begin
            do_grant($sformatf("vec%0d", i), tbl[i].req, tbl[i].two, tbl[i].dly,
                     tbl[i].k, tbl[i].l, tbl[i].rep, tbl[i].two_exp, 1'b1);
        end

        // All requesting: pointer is at 0, expect 0..7 then 0 again
        for (int i = 0; i < 9; i++) begin
            do_grant($sformatf("rr%0d", i), 8'hFF, 8'b1010_1010, 1,
                     16'(i), 16'(100 + i), i % 8, (i % 2) == 1, 1'b0);
        end
        rep_req = '0;

        // Seed wins over a simultaneous request, then the request is served
        seed_load = 1'b1;
        seed      = 64'hFEED_0000_BEEF_0001;
        rep_req   = 8'b0000_0001;
        rep_two   = '0;
        step();
        seed_load = 1'b0;
        chk("prio gen_init", gen_init, 1);
        chk("prio gen_run", gen_run, 0);
        chk("prio gen_seed", gen_seed, 64'hFEED_0000_BEEF_0001);
        step();
        chk("prio idle busy", busy, 0);
        do_grant("prio", 8'b0000_0001, 8'b0000_0000, 2, 16'h0AAA, 16'h0BBB, 0, 1'b0, 1'b1);

        // Timeout: pointer at 1, only replica 3 asks, generator never answers
        rep_req = 8'b0000_1000;
        step();
        chk("tmo cur_rep", cur_rep, 3);
        rep_req = '0;
        step();
        step();
        for (int w = 1; w <= 16; w++) begin
            chk($sformatf("tmo wait%0d busy", w), busy, 1);
            chk($sformatf("tmo wait%0d rep_valid", w), rep_valid, 0);
            step();
        end
        chk("tmo timeout_err", timeout_err, 1);
        chk("tmo busy", busy, 0);
        chk("tmo rep_valid", rep_valid, 0);
        do_grant("post_tmo", 8'b0001_0001, 8'b0001_0000, 2, 16'h0100, 16'h0200, 4, 1'b1, 1'b1);
        chk("post_tmo sticky", timeout_err, 1);

        // Reset while waiting on the generator
        rep_req = 8'b0000_0010;
        step();
        chk("rst cur_rep", cur_rep, 1);
        rep_req = '0;
        step();
        step();
        step();
        reset = 1'b0;
        #1;
        chk_reset("midrst");
        step();
        reset     = 1'b1;
        gen_ready = 1'b1;
        gen_opt   = '{k: 16'h1, l: 16'h2, r_metropolis: 32'h3, r_exchange: 32'h4};
        step();
        gen_ready = 1'b0;
        gen_opt   = '1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("postrst%0d rep_valid", c), rep_valid, 0);
            chk($sformatf("postrst%0d busy", c), busy, 0);
            step();
        end
        chk("postrst rep_opt", rep_opt, 0);
        do_grant("after_rst", 8'b1000_0010, 8'b0000_0000, 1, 16'h0555, 16'h0666, 1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
